dmem_bridge: RTL and testbench

- Sits directly downstream of the MEM-stage data memory controller and converts its level-held request (ReadEnable / WriteEnable[3:0]) into a one-cycle DataMem_Ready pulse plus registered MReadData.
- Drives a valid/grant system memory bus shared with DMA/GPU.
- Stores are posted through a small write buffer so the pipeline does not wait for RAM.
- Loads drain the buffer first, preserving program order.

---
 rtl/dmem_bridge_pkg.sv | 25 ++
 rtl/dmem_wbuf.sv | 53 +++++
 rtl/dmem_bridge.sv | 170 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge and its write buffer.
package dmem_bridge_pkg;

  // Bridge control states.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACK      = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_RD_REQ   = 3'd3,
    S_RD_WAIT  = 3'd4
  } dmem_state_t;

  // Byte enables used for every bus read.
  localparam logic [3:0] BE_ALL = 4'b1111;

  // One posted store: word address, byte lanes, lane-aligned data.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int unsigned WBUF_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-store FIFO: wrap-bit pointers, head-of-queue read, push/pop same cycle.
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned WBUF_AW    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WBUF_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [WBUF_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [WBUF_AW:0] PTR_ONE = {{WBUF_AW{1'b0}}, 1'b1};

  logic [WBUF_AW:0]  r_wr_ptr;
  logic [WBUF_AW:0]  r_rd_ptr;
  logic [WBUF_W-1:0] r_mem [WBUF_DEPTH];
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[WBUF_AW] != r_rd_ptr[WBUF_AW]) &&
                   (r_wr_ptr[WBUF_AW-1:0] == r_rd_ptr[WBUF_AW-1:0]);

  // Push acceptance looks at the pre-pop full flag, so a full FIFO stalls
  // one cycle even when a pop happens at the same edge.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_head = r_mem[r_rd_ptr[WBUF_AW-1:0]];

  // Pointer update; reset discards all buffered entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr[WBUF_AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage data memory bridge: posts stores through a write buffer, drains
// the buffer before each load, and turns completions into a one-cycle Ready.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned WBUF_AW    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [3:0]  WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  output logic        DataMem_Ready,
  output logic [31:0] MReadData,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wbuf_empty
);

  dmem_state_t r_state;
  dmem_state_t w_next_state;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_pending;
  logic        w_start_wr;
  logic        w_ready;
  wbuf_entry_t w_push_entry;
  wbuf_entry_t w_head;

  logic [29:0] r_rd_addr;
  logic [31:0] r_rdata;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [29:0] r_bus_addr;
  logic [31:0] r_bus_wdata;

  logic        w_unused_addr_lo;
  assign w_unused_addr_lo = ^Address[1:0];

  assign w_push_entry = '{addr: Address[31:2], be: WriteEnable, data: MWriteData};

  // A write is on the bus until granted; only then does it leave the buffer.
  assign w_wr_pending = r_bus_req && r_bus_we;
  assign w_pop        = w_wr_pending && bus_gnt;

  dmem_wbuf #(
    .WBUF_DEPTH (WBUF_DEPTH),
    .WBUF_AW    (WBUF_AW)
  ) u_wbuf (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, buffer push and completion pulse.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (WriteEnable != '0) begin
          if (!w_full) begin
            w_push       = 1'b1;
            w_next_state = S_ACK;
          end
        end else if (ReadEnable) begin
          w_next_state = S_RD_DRAIN;
        end
      end
      S_ACK: begin
        w_ready      = 1'b1;
        w_next_state = S_IDLE;
      end
      S_RD_DRAIN: begin
        if (w_empty && !w_wr_pending) w_next_state = S_RD_REQ;
      end
      S_RD_REQ: begin
        if (bus_gnt) w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus_rvalid) w_next_state = S_ACK;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The head only advances after the pop edge, so a new write is launched
  // only from an idle bus; back-to-back writes have one idle cycle between.
  assign w_start_wr = !r_bus_req && !w_empty &&
                      (w_next_state != S_RD_REQ) && (w_next_state != S_RD_WAIT);

  // Registered bus outputs, held stable while a request waits for grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (r_bus_req && !bus_gnt) begin
      r_bus_req   <= r_bus_req;
    end else if (w_next_state == S_RD_REQ) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= 1'b0;
      r_bus_be    <= BE_ALL;
      r_bus_addr  <= r_rd_addr;
    end else if (w_start_wr) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= 1'b1;
      r_bus_be    <= w_head.be;
      r_bus_addr  <= w_head.addr;
      r_bus_wdata <= w_head.data;
    end else begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
    end
  end

  // Load address capture when a read (and no write) is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
    end else if (r_state == S_IDLE && WriteEnable == '0 && ReadEnable) begin
      r_rd_addr <= Address[31:2];
    end
  end

  // Load data register, held until the next load returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == S_RD_WAIT && bus_rvalid) begin
      r_rdata <= bus_rdata;
    end
  end

  assign DataMem_Ready = w_ready;
  assign MReadData     = r_rdata;
  assign bus_req       = r_bus_req;
  assign bus_we        = r_bus_we;
  assign bus_be        = r_bus_be;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;
  assign wbuf_empty    = w_empty && !w_wr_pending;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stores, ordered loads, full buffer, reset.
module tb_dmem_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        ReadEnable;
  logic [3:0]  WriteEnable;
  logic [31:0] Address;
  logic [31:0] MWriteData;
  logic        DataMem_Ready;
  logic [31:0] MReadData;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wbuf_empty;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  dmem_bridge #(
    .WBUF_DEPTH (4),
    .WBUF_AW    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ReadEnable    (ReadEnable),
    .WriteEnable   (WriteEnable),
    .Address       (Address),
    .MWriteData    (MWriteData),
    .DataMem_Ready (DataMem_Ready),
    .MReadData     (MReadData),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_be        (bus_be),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_gnt       (bus_gnt),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .wbuf_empty    (wbuf_empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned cyc;

    reset = 1'b1; ReadEnable = 1'b0; WriteEnable = '0; Address = '0;
    MWriteData = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(DataMem_Ready), 32'd0);
    chk("rst_rdata", MReadData, 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
    reset = 1'b0;
    tick();

    // Single store with grant tied high.
    bus_gnt = 1'b1; WriteEnable = 4'b0011; Address = 32'h0000_1002; MWriteData = 32'hAAAA_BBBB;
    tick();
    chk("t1_ready", 32'(DataMem_Ready), 32'd1);
    chk("t1_wbuf_busy", 32'(wbuf_empty), 32'd0);
    WriteEnable = '0;
    tick();
    chk("t1_ready_drop", 32'(DataMem_Ready), 32'd0);
    chk("t1_req", 32'(bus_req), 32'd1);
    chk("t1_we", 32'(bus_we), 32'd1);
    chk("t1_be", 32'(bus_be), 32'h3);
    chk("t1_addr", 32'(bus_addr), 32'h400);
    chk("t1_wdata", bus_wdata, 32'hAAAA_BBBB);
    tick();
    chk("t1_req_done", 32'(bus_req), 32'd0);
    chk("t1_wbuf_empty", 32'(wbuf_empty), 32'd1);

    // Store then immediate load of same word; write must reach the bus first.
    bus_gnt = 1'b0; WriteEnable = 4'b1111; Address = 32'h100; MWriteData = 32'h1234_5678;
    tick();
    chk("t2_st_ready", 32'(DataMem_Ready), 32'd1);
    WriteEnable = '0; ReadEnable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_wr_held_req", 32'(bus_req), 32'd1);
      chk("t2_wr_held_we", 32'(bus_we), 32'd1);
      chk("t2_wr_held_addr", 32'(bus_addr), 32'h40);
      chk("t2_no_ready", 32'(DataMem_Ready), 32'd0);
    end
    chk("t2_wr_wdata", bus_wdata, 32'h1234_5678);
    bus_gnt = 1'b1;
    tick();
    chk("t2_gap_req", 32'(bus_req), 32'd0);
    chk("t2_gap_ready", 32'(DataMem_Ready), 32'd0);
    tick();
    chk("t2_rd_req", 32'(bus_req), 32'd1);
    chk("t2_rd_we", 32'(bus_we), 32'd0);
    chk("t2_rd_be", 32'(bus_be), 32'hF);
    chk("t2_rd_addr", 32'(bus_addr), 32'h40);
    tick();
    chk("t2_wait_req", 32'(bus_req), 32'd0);
    chk("t2_wait_ready", 32'(DataMem_Ready), 32'd0);
    bus_gnt = 1'b0;
    tick();
    chk("t2_wait2_ready", 32'(DataMem_Ready), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    chk("t2_ld_ready", 32'(DataMem_Ready), 32'd1);
    chk("t2_ld_data", MReadData, 32'h1234_5678);
    bus_rvalid = 1'b0; bus_rdata = '0; ReadEnable = 1'b0;
    tick();
    chk("t2_ready_drop", 32'(DataMem_Ready), 32'd0);

    // Fill the buffer with grant low; the fifth store must stall.
    bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WriteEnable = 4'b1111; Address = 32'h200 + 32'(4 * i); MWriteData = 32'h1111_0000 + 32'(i);
      tick();
      chk("t3_fill_ready", 32'(DataMem_Ready), 32'd1);
      WriteEnable = '0;
      tick();
      chk("t3_fill_ready_drop", 32'(DataMem_Ready), 32'd0);
    end
    WriteEnable = 4'b1111; Address = 32'h210; MWriteData = 32'h1111_0004;
    tick();
    chk("t3_stall_ready", 32'(DataMem_Ready), 32'd0);
    chk("t3_stall_addr", 32'(bus_addr), 32'h80);
    tick();
    chk("t3_stall_ready2", 32'(DataMem_Ready), 32'd0);
    bus_gnt = 1'b1;
    tick();
    chk("t3_pop_ready", 32'(DataMem_Ready), 32'd0);
    chk("t3_pop_req", 32'(bus_req), 32'd0);
    bus_gnt = 1'b0;
    tick();
    chk("t3_push5_ready", 32'(DataMem_Ready), 32'd1);
    chk("t3_next_req", 32'(bus_req), 32'd1);
    chk("t3_next_addr", 32'(bus_addr), 32'h81);
    WriteEnable = '0; bus_gnt = 1'b1;
    k = 0; cyc = 0;
    while (!wbuf_empty && cyc < 20) begin
      if (bus_req) begin
        chk("t3_drain_addr", 32'(bus_addr), 32'h81 + 32'(k));
        chk("t3_drain_wdata", bus_wdata, 32'h1111_0001 + 32'(k));
        k++;
      end
      tick();
      cyc++;
    end
    chk("t3_drain_count", 32'(k), 32'd4);
    chk("t3_wbuf_empty", 32'(wbuf_empty), 32'd1);

    // Minimum-latency load.
    ReadEnable = 1'b1; Address = 32'h3000; bus_gnt = 1'b1;
    tick();
    chk("t4_n1_ready", 32'(DataMem_Ready), 32'd0);
    chk("t4_n1_req", 32'(bus_req), 32'd0);
    tick();
    chk("t4_n2_req", 32'(bus_req), 32'd1);
    chk("t4_n2_we", 32'(bus_we), 32'd0);
    chk("t4_n2_be", 32'(bus_be), 32'hF);
    chk("t4_n2_addr", 32'(bus_addr), 32'hC00);
    tick();
    chk("t4_n3_req", 32'(bus_req), 32'd0);
    chk("t4_n3_ready", 32'(DataMem_Ready), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t4_n4_ready", 32'(DataMem_Ready), 32'd1);
    chk("t4_n4_data", MReadData, 32'hDEAD_BEEF);
    bus_rvalid = 1'b0; bus_rdata = '0; ReadEnable = 1'b0;
    tick();
    chk("t4_ready_drop", 32'(DataMem_Ready), 32'd0);
    chk("t4_data_hold", MReadData, 32'hDEAD_BEEF);

    // Reset discards a buffered write that is waiting on the bus.
    bus_gnt = 1'b0; WriteEnable = 4'b1111; Address = 32'h600; MWriteData = 32'h0BAD_0BAD;
    tick();
    WriteEnable = '0;
    tick();
    chk("t5a_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5a_req_after", 32'(bus_req), 32'd0);
    chk("t5a_wbuf_empty", 32'(wbuf_empty), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("t5a_stays_idle", 32'(bus_req), 32'd0);

    // Reset while waiting for read data; a late rvalid is ignored.
    ReadEnable = 1'b1; Address = 32'h44; bus_gnt = 1'b1;
    tick(); tick(); tick();
    chk("t5_in_wait_req", 32'(bus_req), 32'd0);
    reset = 1'b1; ReadEnable = 1'b0; bus_gnt = 1'b0;
    tick();
    reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    chk("t5_ready", 32'(DataMem_Ready), 32'd0);
    chk("t5_rdata", MReadData, 32'd0);
    chk("t5_req", 32'(bus_req), 32'd0);
    chk("t5_wbuf_empty", 32'(wbuf_empty), 32'd1);
    bus_rvalid = 1'b0; bus_rdata = '0;
    tick();
    chk("t5_ready_late", 32'(DataMem_Ready), 32'd0);

    // Both enables asserted: handled as a store.
    ReadEnable = 1'b1; WriteEnable = 4'b1111; Address = 32'h500; MWriteData = 32'hCAFE_F00D;
    tick();
    chk("t6_ready", 32'(DataMem_Ready), 32'd1);
    ReadEnable = 1'b0; WriteEnable = '0;
    tick();
    chk("t6_req", 32'(bus_req), 32'd1);
    chk("t6_we", 32'(bus_we), 32'd1);
    chk("t6_addr", 32'(bus_addr), 32'h140);
    chk("t6_wdata", bus_wdata, 32'hCAFE_F00D);
    bus_gnt = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_read_req", 32'(bus_req), 32'd0);
      chk("t6_no_ready", 32'(DataMem_Ready), 32'd0);
      tick();
    end
    chk("t6_wbuf_empty", 32'(wbuf_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
